// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the multiply-accumulate datapath:
// field geometry, special encodings, operand classification and the
// stage records carried through the multiplier pipeline.
package bf16_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] POS_INF = 16'h7F80;
  localparam logic [15:0] NEG_INF = 16'hFF80;

  // Special-case outcome decided at unpack time, in priority order.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  // Unpacked operands after stage 1.
  typedef struct packed {
    logic             sign;
    logic [9:0]       exp;     // two's complement, eA + eB - BIAS
    logic [MAN_W:0]   man_a;   // mantissa with hidden bit
    logic [MAN_W:0]   man_b;
    special_e         special;
  } s1_t;

  // Raw product after stage 2.
  typedef struct packed {
    logic             sign;
    logic [9:0]       exp;
    logic [15:0]      prod;
    special_e         special;
  } s2_t;

  function automatic logic [EXP_W-1:0] exp_of(input logic [15:0] x);
    return x[MAN_W +: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] man_of(input logic [15:0] x);
    return x[MAN_W-1:0];
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (exp_of(x) == '1) && (man_of(x) != '0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (exp_of(x) == '1) && (man_of(x) == '0);
  endfunction

  // Denormals flush to zero on input, so any zero exponent counts as zero.
  function automatic logic is_zero(input logic [15:0] x);
    return exp_of(x) == '0;
  endfunction

endpackage

// File: rtl/bf16_round_pack.sv
// Combinational normalize, round-to-nearest-even and pack of a raw
// 16-bit mantissa product, with special-case override.
module bf16_round_pack
  import bf16_pkg::*;
#(
  parameter logic [15:0] NAN_PATTERN = 16'h7FC0
) (
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [15:0] prod_i,
  input  special_e    special_i,
  output logic [15:0] result_o
);

  logic signed [9:0] e;
  logic [7:0]        kept;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [7:0]        low_sum;   // {carry out of kept[6:0], rounded mantissa}
  logic [6:0]        man;

  // Normalize on p[15], round to nearest even, then pack or saturate.
  always_comb begin
    e = $signed(exp_i);
    if (prod_i[15]) begin
      e      = e + 10'sd1;
      kept   = prod_i[15:8];
      guard  = prod_i[7];
      sticky = |prod_i[6:0];
    end else begin
      kept   = prod_i[14:7];
      guard  = prod_i[6];
      sticky = |prod_i[5:0];
    end

    rnd     = guard & (sticky | kept[0]);
    low_sum = {1'b0, kept[6:0]} + {7'b0, rnd};
    man     = low_sum[6:0];
    // Rounding 0xFF up gives 0x100: bump the exponent, mantissa wraps to 0.
    if (low_sum[7] && kept[7]) e = e + 10'sd1;

    result_o = '0;
    unique case (special_i)
      SP_NAN:  result_o = NAN_PATTERN;
      SP_INF:  result_o = sign_i ? NEG_INF : POS_INF;
      SP_ZERO: result_o = {sign_i, 15'h0};
      default: begin
        if (e >= 10'sd255)     result_o = sign_i ? NEG_INF : POS_INF;
        else if (e <= 10'sd0)  result_o = {sign_i, 15'h0};
        else                   result_o = {sign_i, e[7:0], man};
      end
    endcase
  end

endmodule

// File: rtl/bfloat16_mul_pipelined.sv
// Three-stage pipelined bfloat16 multiplier with valid tracking and a
// global clock-enable so the whole MAC pipeline stalls as a unit.
module bfloat16_mul_pipelined #(
  parameter int          STAGES = 3,
  parameter logic [15:0] QNAN   = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  output logic [15:0] result
);
  import bf16_pkg::*;

  logic [STAGES-1:0] vld_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic [15:0]       result_d, result_q;

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  // Stage 1: unpack operands, classify specials, form the biased exponent sum.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    s1_d   = '0;
    nan_a  = is_nan(A);
    nan_b  = is_nan(B);
    inf_a  = is_inf(A);
    inf_b  = is_inf(B);
    zero_a = is_zero(A);
    zero_b = is_zero(B);

    s1_d.sign  = A[15] ^ B[15];
    s1_d.exp   = {2'b0, exp_of(A)} + {2'b0, exp_of(B)} - 10'(BIAS);
    s1_d.man_a = {|exp_of(A), man_of(A)};
    s1_d.man_b = {|exp_of(B), man_of(B)};

    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      s1_d.special = SP_NAN;
    else if (inf_a || inf_b)
      s1_d.special = SP_INF;
    else if (zero_a || zero_b)
      s1_d.special = SP_ZERO;
    else
      s1_d.special = SP_NONE;
  end

  // Stage 2: 8x8 mantissa multiply; sign, exponent and specials pass through.
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.exp     = s1_q.exp;
    s2_d.special = s1_q.special;
    s2_d.prod    = 16'(s1_q.man_a) * 16'(s1_q.man_b);
  end

  // Stage 3: normalize, round and pack.
  bf16_round_pack #(
    .NAN_PATTERN(QNAN)
  ) u_round_pack (
    .sign_i    (s2_q.sign),
    .exp_i     (s2_q.exp),
    .prod_i    (s2_q.prod),
    .special_i (s2_q.special),
    .result_o  (result_d)
  );

  // Pipeline registers: reset beats clock-enable; ce=0 freezes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      result_q <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
      vld_q    <= {vld_q[STAGES-2:0], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = result_q;

endmodule

// File: tb/tb_bfloat16_mul_pipelined.sv
// Directed-vector bench for bfloat16_mul_pipelined with a scoreboard queue
// filled by the driver and drained by an independent output monitor.
module tb_bfloat16_mul_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    int          due;   // enabled-edge count at which the result must appear
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   ce_edges = 0;
  logic last_en  = 1'b0;

  bfloat16_mul_pipelined #(
    .STAGES(3),
    .QNAN  (16'h7FC0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Count enabled edges; remember whether the last edge could have produced a new output.
  always @(posedge clk) begin
    if (!rst && ce) ce_edges <= ce_edges + 1;
    last_en <= ce && !rst;
  end

  // Monitor: on each fresh output, pop the scoreboard and compare value and timing.
  always @(negedge clk) begin
    exp_t e;
    if (last_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result %h with no pending op at %0t", result, $time);
        end else begin
          e = sb.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("latency", 32'(ce_edges), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= ce_edges) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_out: no out_valid for expected %h at %0t", e.res, $time);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    ce       = c;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res);
    exp_t e;
    e.res = exp_res;
    e.due = ce_edges + 3;
    sb.push_back(e);
    drive(1'b1, a, b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[$] = '{
    '{16'h4480, 16'h3F80, 16'h4480},  // 1024 x 1
    '{16'h3E80, 16'h3F90, 16'h3E90},  // 0.25 x 1.125
    '{16'h3FC1, 16'h3F81, 16'h3FC3},  // guard=1, sticky=1: round up
    '{16'h3F81, 16'h3F81, 16'h3F82},  // guard=0: truncate
    '{16'h3FB5, 16'h3FB5, 16'h4000},  // rounding carries out of mantissa
    '{16'h7F00, 16'h4000, 16'h7F80},  // overflow to +inf
    '{16'h7F00, 16'h3F80, 16'h7F00},  // largest exponent stays finite
    '{16'h0080, 16'h0080, 16'h0000},  // underflow to zero
    '{16'h2000, 16'h1F80, 16'h0000},  // e == 0 flushes
    '{16'h2000, 16'h2000, 16'h0080},  // e == 1 is smallest normal
    '{16'h7F80, 16'h0000, 16'h7FC0},  // inf x zero
    '{16'hFF80, 16'h4000, 16'hFF80},  // -inf x 2
    '{16'h7FC1, 16'h3F80, 16'h7FC0},  // NaN operand
    '{16'hFF80, 16'h0000, 16'h7FC0},  // -inf x zero is positive QNAN
    '{16'h0000, 16'hC000, 16'h8000},  // signed zero
    '{16'h0001, 16'h4000, 16'h0000}   // denormal input flushes
  };

  initial begin
    rst      = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    A        = 16'h0;
    B        = 16'h0;

    // Reset state.
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_result", 32'(result), 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic product, then silence so a second out_valid would be flagged.
    issue(16'h4000, 16'hC040, 16'hC0C0);
    idle(6);

    // Back-to-back stream of the directed table.
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].r);
    idle(6);

    // Stall: P emerges on the issue edge of X, then ce drops for 4 cycles
    // with junk valid inputs that must be ignored.
    issue(16'h4000, 16'hC040, 16'hC0C0);
    idle(1);
    issue(16'h3F81, 16'h3F81, 16'h3F82);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h4000, 16'h4000, 1'b0);
      check("stall_hold_valid", 32'(out_valid), 32'h1);
      check("stall_hold_result", 32'(result), 32'h0000C0C0);
    end
    idle(6);

    // Reset mid-flight: two ops issued, reset one cycle later discards both.
    issue(16'h4000, 16'h4000, 16'h4080);
    issue(16'h3F80, 16'h3F80, 16'h3F80);
    sb.delete();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    check("midreset_result", 32'(result), 32'h0);
    rst = 1'b0;
    idle(5);

    // Pipeline resumes cleanly after the mid-flight reset.
    issue(16'h4000, 16'hC040, 16'hC0C0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    check("drain_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
